// File: rtl/instr_fmt_pkg.sv
// rtl/instr_fmt_pkg.sv - format codes and decoded-entry type for the decode stage
package instr_fmt_pkg;

  localparam logic [1:0] FMT_RRR = 2'd0;
  localparam logic [1:0] FMT_RRI = 2'd1;
  localparam logic [1:0] FMT_RI  = 2'd2;
  localparam logic [1:0] FMT_LI  = 2'd3;

  // Field widths of the default 16-bit configuration.
  localparam int DEF_XLEN = 16;
  localparam int DEF_RW   = 3;
  localparam int DEF_IMMW = 16;
  localparam int DEF_OPW  = DEF_XLEN - 3 * DEF_RW - 2;

  typedef struct packed {
    logic [DEF_OPW-1:0]  opc;
    logic [DEF_RW-1:0]   ra;
    logic [DEF_RW-1:0]   rb;
    logic [DEF_RW-1:0]   rc;
    logic [DEF_IMMW-1:0] imm;
    logic [1:0]          fmt;
  } dec_entry_t;

endpackage

// File: rtl/field_slice.sv
// rtl/field_slice.sv - combinational split of an instruction word into decoded fields
module field_slice
  import instr_fmt_pkg::*;
#(
  parameter int XLEN = 16,
  parameter int RW   = 3,
  parameter int IMMW = 16
) (
  input  logic [XLEN-1:0]       instr,
  input  logic [1:0]            fmt,
  input  logic                  sext,
  output logic [XLEN-3*RW-3:0]  opc,
  output logic [RW-1:0]         ra,
  output logic [RW-1:0]         rb,
  output logic [RW-1:0]         rc,
  output logic [IMMW-1:0]       imm
);

  localparam int SW = RW + 2;
  localparam int LW = 2 * RW + 2;

  logic [RW-1:0]   fa;
  logic [RW-1:0]   fb;
  logic [RW-1:0]   fc;
  logic [SW-1:0]   short_src;
  logic [LW-1:0]   long_src;
  logic [IMMW-1:0] short_ext;
  logic [IMMW-1:0] long_ext;

  assign opc       = instr[XLEN-1:3*RW+2];
  assign fa        = instr[3*RW+1:2*RW+2];
  assign fb        = instr[2*RW+1:RW+2];
  assign fc        = instr[RW+1:2];
  assign short_src = instr[SW-1:0];
  assign long_src  = instr[LW-1:0];

  // A sized cast of a signed operand replicates its MSB; of an unsigned one, zero-fills.
  assign short_ext = sext ? IMMW'($signed(short_src)) : IMMW'(short_src);
  assign long_ext  = sext ? IMMW'($signed(long_src))  : IMMW'(long_src);

  always_comb begin
    ra  = '0;
    rb  = '0;
    rc  = '0;
    imm = '0;
    case (fmt)
      FMT_RRR: begin
        ra = fa;
        rb = fb;
        rc = fc;
      end
      FMT_RRI: begin
        ra  = fa;
        rb  = fb;
        rc  = fc;
        imm = short_ext;
      end
      FMT_RI: begin
        rb  = fa;
        rc  = fb;
        imm = short_ext;
      end
      default: begin
        rb  = fa;
        imm = long_ext;
      end
    endcase
  end

endmodule

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - decode stage: field split into a 2-entry output buffer
module instr_field_decode
  import instr_fmt_pkg::*;
#(
  parameter int XLEN = 16,
  parameter int RW   = 3,
  parameter int IMMW = 16,
  parameter int CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_instr,
  input  logic [1:0]            in_fmt,
  input  logic                  in_sext,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-3*RW-3:0]  out_opc,
  output logic [RW-1:0]         out_ra,
  output logic [RW-1:0]         out_rb,
  output logic [RW-1:0]         out_rc,
  output logic [IMMW-1:0]       out_imm,
  output logic [1:0]            out_fmt,
  output logic [CNTW-1:0]       dec_count
);

  localparam int OPW = XLEN - 3 * RW - 2;

  if (XLEN < 3 * RW + 3) begin : g_bad_xlen
    $error("instr_field_decode: XLEN too small for three register fields");
  end
  if (IMMW < 2 * RW + 2) begin : g_bad_immw
    $error("instr_field_decode: IMMW narrower than the long immediate");
  end

  typedef struct packed {
    logic [OPW-1:0]  opc;
    logic [RW-1:0]   ra;
    logic [RW-1:0]   rb;
    logic [RW-1:0]   rc;
    logic [IMMW-1:0] imm;
    logic [1:0]      fmt;
  } entry_t;

  entry_t          dec_entry;
  entry_t          head_q;
  entry_t          tail_q;
  entry_t          head_d;
  entry_t          tail_d;
  logic [1:0]      count_q;
  logic [1:0]      count_d;
  logic [CNTW-1:0] dec_count_q;
  logic [CNTW-1:0] dec_count_d;
  logic            push;
  logic            pop;

  field_slice #(
    .XLEN (XLEN),
    .RW   (RW),
    .IMMW (IMMW)
  ) u_field_slice (
    .instr (in_instr),
    .fmt   (in_fmt),
    .sext  (in_sext),
    .opc   (dec_entry.opc),
    .ra    (dec_entry.ra),
    .rb    (dec_entry.rb),
    .rc    (dec_entry.rc),
    .imm   (dec_entry.imm)
  );
  assign dec_entry.fmt = in_fmt;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // head_q is always the oldest entry; tail_q only matters when two are held.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    dec_count_d = dec_count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        dec_count_d = dec_count_q + 1'b1;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = dec_entry;
          end else begin
            tail_d = dec_entry;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry held: the new word replaces the retired head.
          head_d = dec_entry;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      dec_count_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign out_opc   = head_q.opc;
  assign out_ra    = head_q.ra;
  assign out_rb    = head_q.rb;
  assign out_rc    = head_q.rc;
  assign out_imm   = head_q.imm;
  assign out_fmt   = head_q.fmt;
  assign dec_count = dec_count_q;

endmodule
